// File: rtl/adsr_envelope_bank.sv
// Bank of NUM_VOICES linear ADSR envelope generators.
// All voices share one tick prescaler and one set of A/D/S/R controls.
// Each voice has its own gate edge detector, rate counter and state.
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   gate_i           per-voice note gate (level; edges detected internally)
//   attack_rate_i    attack step every attack_rate_i+1 ticks
//   decay_rate_i     decay step every decay_rate_i+1 ticks
//   sustain_pct_i    sustain level selector
//   release_rate_i   release step every release_rate_i+1 ticks
//   amplitude_o      voice v at [v*AMP_WIDTH +: AMP_WIDTH]
//   active_o         1 while a voice is not idle
//   release_done_o   one-cycle pulse when a voice finishes its release
module adsr_envelope_bank #(
  parameter int unsigned NUM_VOICES    = 4,
  parameter int unsigned PERCENT_WIDTH = 7,
  parameter int unsigned AMP_WIDTH     = 16,
  parameter int unsigned STEP_SIZE     = 64,
  parameter int unsigned PRESCALE      = 763
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_VOICES-1:0]           gate_i,
  input  logic [PERCENT_WIDTH-1:0]        attack_rate_i,
  input  logic [PERCENT_WIDTH-1:0]        decay_rate_i,
  input  logic [PERCENT_WIDTH-1:0]        sustain_pct_i,
  input  logic [PERCENT_WIDTH-1:0]        release_rate_i,
  output logic [NUM_VOICES*AMP_WIDTH-1:0] amplitude_o,
  output logic [NUM_VOICES-1:0]           active_o,
  output logic [NUM_VOICES-1:0]           release_done_o
);

  typedef enum logic [2:0] {StIdle, StAttack, StDecay, StSustain, StRelease} state_e;

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);
  // Amplitude arithmetic is done one bit wider so saturation/underflow is exact.
  localparam logic [AMP_WIDTH:0] AmpMaxX = {1'b0, {AMP_WIDTH{1'b1}}};
  localparam logic [AMP_WIDTH:0] StepX   = (AMP_WIDTH + 1)'(STEP_SIZE);

  // Shared time base
  logic [PsW-1:0] ps_q;
  logic           tick;

  assign tick = (ps_q == PsLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps_q <= '0;
    end else if (tick) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + 1'b1;
    end
  end

  // Sustain level: replicate the LSB so 0 maps to 0 and all-ones maps to all-ones.
  logic [AMP_WIDTH-1:0] sus_lvl;
  assign sus_lvl = {sustain_pct_i, {(AMP_WIDTH - PERCENT_WIDTH){sustain_pct_i[0]}}};

  // Per-voice state
  state_e                   state_q [NUM_VOICES];
  state_e                   state_d [NUM_VOICES];
  logic [AMP_WIDTH-1:0]     amp_q   [NUM_VOICES];
  logic [AMP_WIDTH-1:0]     amp_d   [NUM_VOICES];
  logic [PERCENT_WIDTH-1:0] cnt_q   [NUM_VOICES];
  logic [PERCENT_WIDTH-1:0] cnt_d   [NUM_VOICES];
  logic [PERCENT_WIDTH-1:0] rate    [NUM_VOICES];
  logic [AMP_WIDTH:0]       sum     [NUM_VOICES];
  logic [AMP_WIDTH:0]       diff    [NUM_VOICES];
  logic [NUM_VOICES-1:0]    gate_q;
  logic [NUM_VOICES-1:0]    rise;
  logic [NUM_VOICES-1:0]    fall;
  logic [NUM_VOICES-1:0]    step;
  logic [NUM_VOICES-1:0]    done_d;
  logic [NUM_VOICES-1:0]    done_q;
  logic [NUM_VOICES-1:0]    active_d;
  logic [NUM_VOICES-1:0]    active_q;

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      state_d[v]  = state_q[v];
      amp_d[v]    = amp_q[v];
      cnt_d[v]    = cnt_q[v];
      done_d[v]   = 1'b0;
      step[v]     = 1'b0;
      rise[v]     = gate_i[v] & ~gate_q[v];
      fall[v]     = ~gate_i[v] & gate_q[v];
      sum[v]      = {1'b0, amp_q[v]} + StepX;
      diff[v]     = {1'b0, amp_q[v]} - StepX;

      // Rate inputs are used live, so a change applies at the next compare.
      unique case (state_q[v])
        StAttack:  rate[v] = attack_rate_i;
        StDecay:   rate[v] = decay_rate_i;
        StRelease: rate[v] = release_rate_i;
        default:   rate[v] = '0;
      endcase

      if (tick && (state_q[v] == StAttack || state_q[v] == StDecay ||
                   state_q[v] == StRelease)) begin
        if (cnt_q[v] == rate[v]) begin
          step[v]  = 1'b1;
          cnt_d[v] = '0;
        end else begin
          cnt_d[v] = cnt_q[v] + 1'b1;
        end
      end

      // Gate edges win over a coincident step; the step is dropped.
      if (rise[v]) begin
        state_d[v] = StAttack;
        cnt_d[v]   = '0;
      end else if (fall[v] && (state_q[v] == StAttack || state_q[v] == StDecay ||
                               state_q[v] == StSustain)) begin
        state_d[v] = StRelease;
        cnt_d[v]   = '0;
      end else begin
        unique case (state_q[v])
          StIdle: begin
            amp_d[v] = '0;
            cnt_d[v] = '0;
          end
          StAttack: begin
            if (step[v]) begin
              if (sum[v] >= AmpMaxX) begin
                amp_d[v]   = AmpMaxX[AMP_WIDTH-1:0];
                state_d[v] = StDecay;
              end else begin
                amp_d[v] = sum[v][AMP_WIDTH-1:0];
              end
            end
          end
          StDecay: begin
            if (step[v]) begin
              // Guard bit set means the subtraction went below zero.
              if (diff[v][AMP_WIDTH] || (diff[v][AMP_WIDTH-1:0] <= sus_lvl)) begin
                amp_d[v]   = sus_lvl;
                state_d[v] = StSustain;
              end else begin
                amp_d[v] = diff[v][AMP_WIDTH-1:0];
              end
            end
          end
          StSustain: begin
            amp_d[v] = sus_lvl;
            cnt_d[v] = '0;
          end
          StRelease: begin
            if (step[v]) begin
              if ({1'b0, amp_q[v]} <= StepX) begin
                amp_d[v]   = '0;
                state_d[v] = StIdle;
                done_d[v]  = 1'b1;
              end else begin
                amp_d[v] = diff[v][AMP_WIDTH-1:0];
              end
            end
          end
          default: begin
            state_d[v] = StIdle;
            amp_d[v]   = '0;
            cnt_d[v]   = '0;
          end
        endcase
      end

      active_d[v] = (state_d[v] != StIdle);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= StIdle;
        amp_q[v]   <= '0;
        cnt_q[v]   <= '0;
      end
      gate_q   <= '0;
      done_q   <= '0;
      active_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= state_d[v];
        amp_q[v]   <= amp_d[v];
        cnt_q[v]   <= cnt_d[v];
      end
      gate_q   <= gate_i;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    amplitude_o = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      amplitude_o[v*AMP_WIDTH +: AMP_WIDTH] = amp_q[v];
    end
  end

  assign active_o       = active_q;
  assign release_done_o = done_q;

endmodule
